hex_display_arbiter: RTL
========================

Name: hex_display_arbiter

Overview:
- Time-shares the single 16-bit value on the four-digit seven-segment display (HEX3..HEX0) between four requesters, for example the sequencing FSM, a debug register and a counter.
- Round-robin arbitration with a programmable dwell time per grant.
- A lock input pins the current owner on the display.
- The `out` port drives the existing four hex_to_7seg decoders directly (nibble 3 to HEX3 ... nibble 0 to HEX0).

Parameters:
- DWELL, 50000000: cycles each grant is shown before rotation (1 s at 50 MHz); must be at least 2.
- CW, 26: dwell counter width; must satisfy 2^CW >= DWELL.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-requester display request; req[i] belongs to data_i.
- data_0  input  16  value offered by requester 0.
- data_1  input  16  value offered by requester 1.
- data_2  input  16  value offered by requester 2.
- data_3  input  16  value offered by requester 3.
- lock  input  1  when high, suppresses rotation at dwell expiry.
- grant  output  4  one-hot owner of the display; all zero when idle.
- sel  output  2  index of the current or last owner.
- active  output  1  high while in SHOW.
- out  output  16  value to display; nibble 3 drives HEX3 (leftmost).

Behaviour:
- Single clock domain; all outputs are registered. rst is sampled on the clk rising edge.
- Reset values:
  - grant = 0, sel = 0, active = 0, out = 16'h0000.
  - cnt = 0, state = IDLE.
  - Internal pointer ptr = 3, so the first search starts at index 0.
- Winner search, round-robin:
  - Candidates in order (base+1), (base+2), (base+3), base, all modulo 4.
  - The first candidate with req set wins.
  - base = ptr in IDLE; base = sel at dwell expiry.
- IDLE:
  - If req == 0: stay in IDLE; out and sel hold their values.
  - Else, at the edge: state = SHOW, grant = onehot(w), sel = w, out = data_w, cnt = 0, active = 1.
  - Latency: req sampled high at edge n gives grant and out valid after edge n (one cycle from the req change).
- SHOW (owner s = sel), priority in this order:
  1. req[s] low: grant = 0, active = 0, ptr = s, state = IDLE. out holds its last value, with no blanking.
  2. cnt == DWELL-1 and lock low: re-arbitrate from base s in the same edge, with no idle bubble. Winner w gets grant, sel, out = data_w and cnt = 0. If s is the only requester, it wins again and its dwell restarts.
  3. cnt == DWELL-1 and lock high: cnt = 0 and the owner is retained.
  4. Otherwise: cnt = cnt + 1 and out = data_s. This is a live refresh every cycle, so the owner may change its value mid-dwell.
- Boundary cases:
  - lock only matters at expiry. Asserting it mid-dwell does not reset cnt. Deasserting it lets the next expiry rotate.
  - A new req arriving mid-dwell waits for expiry or for the owner to drop; there is no preemption.
  - Owner dropping req in the same cycle as expiry: rule 1 wins. Go to IDLE; the next search starts from s+1 one cycle later.
  - req bits other than the owner's may toggle freely. Only values at the arbitration edge matter.
  - rst mid-SHOW returns every output to its reset value on that edge, regardless of req or lock.
  - cnt never exceeds DWELL-1. grant is always zero or one-hot.
  - The data_i inputs are sampled only when granted.

Test Plan (DWELL=4):
- Reset: hold rst high for 2 cycles with req=4'b1111 -> grant=0, out=0000, active=0. On the first edge after rst falls -> grant=0001, out=data_0.
- Rotation: req=4'b0101, data_0=1234, data_2=ABCD -> out=1234 for 4 cycles, then ABCD for 4 cycles, then 1234; grant alternates 0001/0100 with no idle cycle.
- Single requester: req=4'b1000 only -> grant=1000 continuously; cnt wraps every 4 cycles; out follows data_3 changes in the next cycle.
- Lock: owner 1 with req=4'b0011 and lock=1 -> grant stays 0010 for 12+ cycles. Drop lock -> grant=0001 at the next expiry.
- Drop and empty: owner 2 drops req at cycle 1 of dwell -> next edge grant=0, active=0, out holds last value. Then req=4'b0110 -> winner is 1 (search from 3,0,1...) ... expected grant=0010? No: ptr=2, so the search order is 3,0,1,2 -> grant=0010.
- Reset mid-SHOW: assert rst at cnt=2 -> next edge grant=0, sel=0, out=0000. After release with req=4'b0100 -> grant=0100 after one edge.

Source files
------------

// File: rtl/hex_display_arbiter_if.sv
// Display-arbiter bus: four requesters in, one owner and its value out.
// master is the requester side, slave is the arbiter.
interface hex_display_arbiter_if;
  logic [3:0]  req;
  logic [15:0] data_0;
  logic [15:0] data_1;
  logic [15:0] data_2;
  logic [15:0] data_3;
  logic        lock;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        active;
  logic [15:0] out;

  modport master (
    output req,
    output data_0,
    output data_1,
    output data_2,
    output data_3,
    output lock,
    input  grant,
    input  sel,
    input  active,
    input  out
  );

  modport slave (
    input  req,
    input  data_0,
    input  data_1,
    input  data_2,
    input  data_3,
    input  lock,
    output grant,
    output sel,
    output active,
    output out
  );
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin time-share of the 4-digit hex display between four requesters,
// with a per-grant dwell time and a lock that pins the current owner.
module hex_display_arbiter #(
  parameter int DWELL = 50000000,
  parameter int CW    = 26
) (
  input logic                  clk,
  input logic                  rst,
  hex_display_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE,
    SHOW
  } state_e;

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    grant_q, grant_d;
  logic          active_q, active_d;
  logic [15:0]   out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [15:0] data_a [4];
  logic [1:0]  base;
  logic [1:0]  win;
  logic [1:0]  cand;
  logic        expire;

  always_comb begin
    data_a[0] = bus.data_0;
    data_a[1] = bus.data_1;
    data_a[2] = bus.data_2;
    data_a[3] = bus.data_3;
  end

  assign base   = (state_q == IDLE) ? ptr_q : sel_q;
  assign expire = (cnt_q == LAST);

  // Walk the order base+4 .. base+1 so the nearest requester after base wins.
  always_comb begin
    win  = base;
    cand = base;
    for (int k = 4; k >= 1; k--) begin
      cand = base + k[1:0];
      if (bus.req[cand]) begin
        win = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    grant_d  = grant_q;
    active_d = active_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d  = SHOW;
          grant_d  = 4'b0001 << win;
          sel_d    = win;
          out_d    = data_a[win];
          cnt_d    = '0;
          active_d = 1'b1;
        end
      end
      SHOW: begin
        if (!bus.req[sel_q]) begin
          state_d  = IDLE;
          grant_d  = 4'b0000;
          active_d = 1'b0;
          ptr_d    = sel_q;
        end else if (expire && !bus.lock) begin
          grant_d = 4'b0001 << win;
          sel_d   = win;
          out_d   = data_a[win];
          cnt_d   = '0;
        end else if (expire) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          out_d = data_a[sel_q];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd3;
      sel_q    <= 2'd0;
      grant_q  <= 4'b0000;
      active_q <= 1'b0;
      out_q    <= 16'h0000;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      grant_q  <= grant_d;
      active_q <= active_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.sel    = sel_q;
  assign bus.active = active_q;
  assign bus.out    = out_q;

endmodule
